// File: rtl/rssb_pkg.sv
// Shared types and constants for the RSSB core: default widths, strobe select
// encodings and the location of the optional I/O word.
package rssb_pkg;

    localparam int RSSB_DATA_W = 16;
    localparam int RSSB_ADDR_W = 8;

    typedef enum logic {
        PC_INC1 = 1'b0,
        PC_SKIP = 1'b1
    } pc_inc_t;

    typedef enum logic {
        MEM_PC  = 1'b0,
        MEM_OP1 = 1'b1
    } mem_sel_t;

    // The topmost word of the address space doubles as the I/O port.
    function automatic int mmio_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    localparam int MMIO_ADDR = mmio_addr(RSSB_ADDR_W);

endpackage

// File: rtl/rssb_mem.sv
// Unified program/data RAM for the RSSB core: combinational read, write on clk.
// Contents have no reset value.
module rssb_mem
    import rssb_pkg::*;
#(
    parameter int DATA_W = RSSB_DATA_W,
    parameter int ADDR_W = RSSB_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] ram [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end

    assign rdata = ram[addr];

endmodule

// File: rtl/rssb_datapath.sv
// RSSB datapath: PC, OP1 and ACC registers, the reverse-subtract unit and the
// unified memory, driven by control-FSM strobes. Define RSSB_MMIO_EN to map the
// top address onto io_in/io_out instead of RAM.
module rssb_datapath
    import rssb_pkg::*;
#(
    parameter int DATA_W = RSSB_DATA_W,
    parameter int ADDR_W = RSSB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_pc,
    input  logic              sel_mem,
    input  logic              write_op1,
    input  logic              write_acc,
    input  logic              write_mem,
    input  logic              write_pc,
    output logic              neg,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] acc_o
`ifdef RSSB_MMIO_EN
    ,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_valid
`endif
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] op1;
    logic [DATA_W-1:0] acc;
    logic              neg_q;

    logic [ADDR_W-1:0] core_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W:0]   diff;
    logic [ADDR_W-1:0] pc_next;
    logic              core_wr;

    // Unsigned subtract with the borrow returned in the extra top bit.
    function automatic logic [DATA_W:0] rsub(input logic [DATA_W-1:0] minuend,
                                             input logic [DATA_W-1:0] subtrahend);
        return {1'b0, minuend} - {1'b0, subtrahend};
    endfunction

    function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] cur,
                                                     input pc_inc_t          inc);
        return (inc == PC_SKIP) ? cur + ADDR_W'(2) : cur + ADDR_W'(1);
    endfunction

    assign core_addr = (mem_sel_t'(sel_mem) == MEM_OP1) ? op1 : pc;
    assign diff      = rsub(mem_rdata, acc);
    assign pc_next   = pc_advance(pc, pc_inc_t'(sel_pc));

    // A load owns the memory port for its cycle; a coincident write_mem is dropped.
    assign core_wr   = write_mem & ~load_en & ~rst;
    assign mem_addr  = load_en ? load_addr : core_addr;
    assign mem_wdata = load_en ? load_data : acc;

`ifdef RSSB_MMIO_EN
    logic core_is_io;
    logic load_is_io;

    assign core_is_io = (core_addr == ADDR_W'(mmio_addr(ADDR_W)));
    assign load_is_io = (load_addr == ADDR_W'(mmio_addr(ADDR_W)));
    assign mem_we     = load_en ? ~load_is_io : (core_wr & ~core_is_io);
    assign mem_rdata  = core_is_io ? io_in : ram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_out   <= '0;
            io_valid <= 1'b0;
        end else begin
            io_valid <= core_wr & core_is_io;
            if (core_wr && core_is_io) begin
                io_out <= acc;
            end
        end
    end
`else
    assign mem_we    = load_en | core_wr;
    assign mem_rdata = ram_rdata;
`endif

    rssb_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (ram_rdata)
    );

    // Register update: every strobe samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            op1   <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
        end else begin
            if (write_pc) begin
                pc <= pc_next;
            end
            if (write_op1) begin
                op1 <= mem_rdata[ADDR_W-1:0];
            end
            if (write_acc) begin
                acc   <= diff[DATA_W-1:0];
                neg_q <= diff[DATA_W];
            end
        end
    end

    assign neg   = neg_q;
    assign pc_o  = pc;
    assign acc_o = acc;

endmodule
